// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit. Turns the registered load/store request coming
//   out of EX/MEM into a req/ack transaction on the data-memory port, formats
//   returned load data for MEM/WB, and holds the front of the pipeline with
//   mem_stall while a transaction is outstanding. Misaligned and illegal
//   requests are rejected without touching the bus. A bus transaction that
//   sees no ack for TIMEOUT_CYCLES cycles raises access_fault.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; a legal aligned request issues this edge
//   BUSY  | dmem_req high, dmem_* frozen, waiting for ack or timeout
//   DONE  | transaction finished; pipeline advances, inputs are not re-issued
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   flush                 suppresses issue of the request presented in IDLE
//   MEM_memory_read/write load / store request from EX/MEM
//   MEM_funct3            RV32I load/store size and sign
//   MEM_alu_result        effective byte address
//   MEM_read_data2        store data (rs2)
//   dmem_req/we/addr/wstrb/wdata   registered data-memory request
//   dmem_ack, dmem_rdata  memory completion and read word
//   mem_stall             hold EX/MEM and earlier stages
//   load_data             formatted load result, registered
//   misaligned_exception  one-cycle pulse
//   access_fault          one-cycle pulse (illegal encoding or timeout)
//   fault_addr            byte address of the most recent faulting access
//
// The lane logic assumes a 32-bit data bus (four byte strobes).

module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            MEM_memory_read,
  input  logic            MEM_memory_write,
  input  logic [2:0]      MEM_funct3,
  input  logic [XLEN-1:0] MEM_alu_result,
  input  logic [XLEN-1:0] MEM_read_data2,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned_exception,
  output logic            access_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_funct3;
  logic [1:0]       r_byte_off;
  logic [XLEN-1:0]  r_byte_addr;

  logic             w_access;
  logic             w_illegal;
  logic             w_misaligned;
  logic             w_issue_ok;
  logic             w_timeout;
  logic             w_stall;
  logic [1:0]       w_size;
  logic [1:0]       w_off;
  logic [3:0]       w_wstrb;
  logic [XLEN-1:0]  w_wdata;
  logic [7:0]       w_lane_byte;
  logic [15:0]      w_lane_half;
  logic [XLEN-1:0]  w_load_fmt;

  // ---------------------------------------------------------------------
  // Request classification (only meaningful while IDLE)
  // ---------------------------------------------------------------------
  assign w_size   = MEM_funct3[1:0];
  assign w_off    = MEM_alu_result[1:0];
  assign w_access = (MEM_memory_read | MEM_memory_write) & ~flush;

  // Loads: 011 (LD), 110 (LWU) and 111 are not RV32I. Stores: only SB/SH/SW.
  assign w_illegal = (MEM_memory_read & MEM_memory_write)
                   | (MEM_memory_read  & ((w_size == 2'b11) |
                                          (MEM_funct3[2] & (w_size == 2'b10))))
                   | (MEM_memory_write & (MEM_funct3 >= 3'b011));

  assign w_misaligned = ((w_size == 2'b01) & w_off[0])
                      | ((w_size == 2'b10) & (w_off != 2'b00));

  // An illegal encoding is reported as access_fault even if the address is
  // also misaligned; the size field of an illegal request is not trusted.
  assign w_issue_ok = w_access & ~w_illegal & ~w_misaligned;

  assign w_timeout  = ~dmem_ack & (r_count == CNT_LAST);

  // ---------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = '0;
    if (MEM_memory_write) begin
      unique case (w_size)
        2'b00: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{MEM_read_data2[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{MEM_read_data2[15:0]}};
        end
        default: begin
          w_wstrb = 4'b1111;
          w_wdata = MEM_read_data2;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Load formatting, driven from the size/offset captured at issue
  // ---------------------------------------------------------------------
  assign w_lane_byte = dmem_rdata[{r_byte_off, 3'b000} +: 8];
  assign w_lane_half = dmem_rdata[{r_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load_fmt = dmem_rdata;
    unique case (r_funct3)
      3'b000:  w_load_fmt = {{(XLEN-8){w_lane_byte[7]}}, w_lane_byte};
      3'b100:  w_load_fmt = {{(XLEN-8){1'b0}}, w_lane_byte};
      3'b001:  w_load_fmt = {{(XLEN-16){w_lane_half[15]}}, w_lane_half};
      3'b101:  w_load_fmt = {{(XLEN-16){1'b0}}, w_lane_half};
      default: w_load_fmt = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_issue_ok) begin
          w_state_nxt = ST_BUSY;
          w_stall     = 1'b1;
        end
      end
      ST_BUSY: begin
        w_stall = 1'b1;
        if (dmem_ack | w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The IDLE term of w_stall depends on live inputs, so gate it with reset.
  assign mem_stall = w_stall & ~reset;

  // ---------------------------------------------------------------------
  // Registered outputs and transaction context
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= '0;
      dmem_wstrb           <= 4'b0000;
      dmem_wdata           <= '0;
      load_data            <= '0;
      misaligned_exception <= 1'b0;
      access_fault         <= 1'b0;
      fault_addr           <= '0;
      r_count              <= '0;
      r_funct3             <= 3'b000;
      r_byte_off           <= 2'b00;
      r_byte_addr          <= '0;
    end else begin
      misaligned_exception <= 1'b0;
      access_fault         <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_issue_ok) begin
            dmem_req    <= 1'b1;
            dmem_we     <= MEM_memory_write;
            dmem_addr   <= {MEM_alu_result[XLEN-1:2], 2'b00};
            dmem_wstrb  <= w_wstrb;
            dmem_wdata  <= w_wdata;
            r_count     <= CNT_W'(1);
            r_funct3    <= MEM_funct3;
            r_byte_off  <= w_off;
            r_byte_addr <= MEM_alu_result;
          end else if (w_access & w_illegal) begin
            access_fault <= 1'b1;
            fault_addr   <= MEM_alu_result;
          end else if (w_access & w_misaligned) begin
            misaligned_exception <= 1'b1;
            fault_addr           <= MEM_alu_result;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) load_data <= w_load_fmt;
          end else if (w_timeout) begin
            dmem_req     <= 1'b0;
            load_data    <= '0;
            access_fault <= 1'b1;
            fault_addr   <= r_byte_addr;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
